// File: rtl/brc_seq_if.sv
// ----------------------------------------------------------------------------
// brc_seq_if
// Request/response bundle for the multi-cycle branch comparator brc_seq.
//   Request  : i_valid/o_ready handshake plus operands (i_rs1_data,
//              i_rs2_data, i_imm_ext), operand-B select (i_slti_sel),
//              i_funct3, i_br_un and the abandon strobe i_flush.
//   Response : o_valid/i_ready handshake plus o_br_less, o_br_equal, o_taken.
// Signal names keep the i_/o_ prefixes as seen from the comparator.
// Modports:
//   slave  - the comparator side
//   master - the requester/consumer side
// ----------------------------------------------------------------------------
interface brc_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic [WIDTH-1:0] i_imm_ext;
    logic             i_slti_sel;
    logic [2:0]       i_funct3;
    logic             i_br_un;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_less;
    logic             o_br_equal;
    logic             o_taken;

    modport slave (
        input  i_valid, i_rs1_data, i_rs2_data, i_imm_ext, i_slti_sel,
               i_funct3, i_br_un, i_flush, i_ready,
        output o_ready, o_valid, o_br_less, o_br_equal, o_taken
    );

    modport master (
        output i_valid, i_rs1_data, i_rs2_data, i_imm_ext, i_slti_sel,
               i_funct3, i_br_un, i_flush, i_ready,
        input  o_ready, o_valid, o_br_less, o_br_equal, o_taken
    );
endinterface

// File: rtl/brc_seq.sv
// ----------------------------------------------------------------------------
// brc_seq
// Multi-cycle RISC-V branch comparator. Operands are compared CHUNK bits per
// cycle, least-significant chunk first; the most significant differing chunk
// decides "less". Results are registered and held until the consumer takes
// them.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - brc_seq_if.slave (request + response handshakes and data)
// Parameters:
//   WIDTH  - operand width
//   CHUNK  - bits compared per cycle; must divide WIDTH
// Optional feature macro: BRC_SEQ_EQ_FASTPATH_EN
//   Defined: BEQ/BNE resolve equality with a full-width XOR reduction at
//   accept and finish on the next edge with o_br_less = 0.
//   Undefined: every funct3 takes the serial path.
// ----------------------------------------------------------------------------
module brc_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    brc_seq_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Elaboration-time configuration guard
    generate
        if ((CHUNK <= 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("brc_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Branch resolution from the latched funct3 and the compare flags
    function automatic logic taken_fn(input logic [2:0] f3,
                                      input logic       eq,
                                      input logic       lt);
        logic t;
        case (f3)
            3'b000:         t = eq;
            3'b001:         t = ~eq;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = ~lt;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       f3_q;
    logic             un_q;
    logic             fast_q;
    logic             eq_acc_q;
    logic             lt_acc_q;
    logic             ready_q;
    logic             valid_q;
    logic             less_q;
    logic             equal_q;
    logic             taken_q;

    logic [WIDTH-1:0] b_sel_s;
    logic             fast_sel_s;
    logic             eq_init_s;
    logic             last_s;
    logic [CHUNK-1:0] a_ch_s;
    logic [CHUNK-1:0] b_ch_s;
    logic             eq_d;
    logic             lt_d;

    // Operand-B select and the optional equality fast path decision at accept
    always_comb begin
        b_sel_s = bus.i_slti_sel ? bus.i_imm_ext : bus.i_rs2_data;
`ifdef BRC_SEQ_EQ_FASTPATH_EN
        fast_sel_s = (bus.i_funct3[2:1] == 2'b00);
        eq_init_s  = ~|(bus.i_rs1_data ^ b_sel_s);
`else
        fast_sel_s = 1'b0;
        eq_init_s  = 1'b1;
`endif
    end

    // Current chunk compare; operands are shifted down so the active chunk
    // always sits in the low bits. Flipping the MSB of the top chunk turns a
    // two's-complement compare into an unsigned one.
    always_comb begin
        last_s = (cnt_q == CW'(NCHUNK - 1));
        a_ch_s = a_q[CHUNK-1:0];
        b_ch_s = b_q[CHUNK-1:0];
        if (last_s && !un_q) begin
            a_ch_s[CHUNK-1] = ~a_q[CHUNK-1];
            b_ch_s[CHUNK-1] = ~b_q[CHUNK-1];
        end else begin
            a_ch_s[CHUNK-1] = a_q[CHUNK-1];
            b_ch_s[CHUNK-1] = b_q[CHUNK-1];
        end
        if (a_ch_s != b_ch_s) begin
            lt_d = (a_ch_s < b_ch_s);
            eq_d = 1'b0;
        end else begin
            lt_d = lt_acc_q;
            eq_d = eq_acc_q;
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            f3_q     <= 3'b000;
            un_q     <= 1'b0;
            fast_q   <= 1'b0;
            eq_acc_q <= 1'b1;
            lt_acc_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // i_flush is deliberately ignored here
                    if (bus.i_valid) begin
                        a_q      <= bus.i_rs1_data;
                        b_q      <= b_sel_s;
                        f3_q     <= bus.i_funct3;
                        un_q     <= bus.i_br_un | (bus.i_funct3[2:1] == 2'b11);
                        fast_q   <= fast_sel_s;
                        cnt_q    <= {CW{1'b0}};
                        eq_acc_q <= eq_init_s;
                        lt_acc_q <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= BUSY;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.i_flush) begin
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (fast_q) begin
                        less_q  <= 1'b0;
                        equal_q <= eq_acc_q;
                        taken_q <= taken_fn(f3_q, eq_acc_q, 1'b0);
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else if (last_s) begin
                        less_q  <= lt_d;
                        equal_q <= eq_d;
                        taken_q <= taken_fn(f3_q, eq_d, lt_d);
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        lt_acc_q <= lt_d;
                        eq_acc_q <= eq_d;
                        a_q      <= a_q >> CHUNK;
                        b_q      <= b_q >> CHUNK;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    // Flush and handshake both retire the result; the next
                    // request can only be accepted from IDLE.
                    if (bus.i_flush || bus.i_ready) begin
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_br_less  = less_q;
    assign bus.o_br_equal = equal_q;
    assign bus.o_taken    = taken_q;

endmodule

// File: tb/tb_brc_seq.sv
// ----------------------------------------------------------------------------
// tb_brc_seq
// Directed + randomised bench for brc_seq (WIDTH=32, CHUNK=8). Expected
// results come from a behavioural full-width compare model, are queued when a
// request is accepted and compared when the DUT raises o_valid.
// ----------------------------------------------------------------------------
module tb_brc_seq;
    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int BOUND  = 20;

    typedef struct {
        logic less;
        logic equal;
        logic taken;
        int   lat;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    brc_seq_if #(.WIDTH(WIDTH)) bus ();

    brc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic last_less, last_equal, last_taken;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input logic un);
        exp_t e;
        logic u;
        u       = un | (f3[2:1] == 2'b11);
        e.equal = (a == b);
        e.less  = u ? (a < b) : ($signed(a) < $signed(b));
        case (f3)
            3'b000:         e.taken = e.equal;
            3'b001:         e.taken = ~e.equal;
            3'b100, 3'b110: e.taken = e.less;
            3'b101, 3'b111: e.taken = ~e.less;
            default:        e.taken = 1'b0;
        endcase
        e.lat = NCHUNK;
`ifdef BRC_SEQ_EQ_FASTPATH_EN
        if (f3[2:1] == 2'b00) begin
            e.less = 1'b0;
            e.lat  = 1;
        end
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for one edge (DUT must be idle) and queue its result
    task automatic send(input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic sel, input logic [2:0] f3, input logic un, input logic fl);
        check("ready_before_accept", bus.o_ready, 1);
        bus.i_valid    = 1'b1;
        bus.i_rs1_data = a;
        bus.i_rs2_data = rs2;
        bus.i_imm_ext  = imm;
        bus.i_slti_sel = sel;
        bus.i_funct3   = f3;
        bus.i_br_un    = un;
        bus.i_flush    = fl;
        sb.push_back(model(a, sel ? imm : rs2, f3, un));
        tick();
        bus.i_valid    = 1'b0;
        bus.i_flush    = 1'b0;
        // scramble inputs: they must be ignored after accept
        bus.i_rs1_data = $urandom;
        bus.i_rs2_data = $urandom;
        bus.i_imm_ext  = $urandom;
        bus.i_slti_sel = ~sel;
        bus.i_funct3   = 3'($urandom_range(7));
        bus.i_br_un    = ~un;
        check("ready_low_after_accept", bus.o_ready, 0);
    endtask

    // Wait for the queued result, compare it, optionally stall, then retire it
    task automatic finish(input string tag, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.o_valid && n < BOUND) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check({tag, "_valid_seen"}, bus.o_valid, 1);
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_ready_in_done"}, bus.o_ready, 0);
        check({tag, "_less"}, bus.o_br_less, e.less);
        check({tag, "_equal"}, bus.o_br_equal, e.equal);
        check({tag, "_taken"}, bus.o_taken, e.taken);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, bus.o_valid, 1);
            check({tag, "_hold_ready"}, bus.o_ready, 0);
            check({tag, "_hold_less"}, bus.o_br_less, e.less);
            check({tag, "_hold_equal"}, bus.o_br_equal, e.equal);
            check({tag, "_hold_taken"}, bus.o_taken, e.taken);
        end
        last_less   = e.less;
        last_equal  = e.equal;
        last_taken  = e.taken;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check({tag, "_valid_after_hs"}, bus.o_valid, 0);
        check({tag, "_ready_after_hs"}, bus.o_ready, 1);
    endtask

    initial begin
        logic [31:0] ra, rb, mask;
        logic [2:0]  rf;
        bus.i_valid    = 1'b0;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_imm_ext  = '0;
        bus.i_slti_sel = 1'b0;
        bus.i_funct3   = 3'b000;
        bus.i_br_un    = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_ready    = 1'b0;
        i_rst          = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_less", bus.o_br_less, 0);
        check("rst_equal", bus.o_br_equal, 0);
        check("rst_taken", bus.o_taken, 0);

        send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        finish("blt_neg1_vs_1", 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 3'b110, 1'b0, 1'b0);
        finish("bltu_max_vs_1", 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 3'b111, 1'b0, 1'b0);
        finish("bgeu_max_vs_1", 0);
        send(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 3'b101, 1'b0, 1'b0);
        finish("bge_imm_sel", 0);
        send(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        finish("beq_equal", 0);
        send(32'h0100_0000, 32'h0000_0000, 32'h0, 1'b0, 3'b001, 1'b0, 1'b0);
        finish("bne_top_chunk", 0);
        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        finish("blt_signed_extremes", 0);
        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 3'b100, 1'b1, 1'b0);
        finish("blt_br_un", 0);
        send(32'h0000_01FF, 32'h0000_0200, 32'h0, 1'b0, 3'b110, 1'b0, 1'b0);
        finish("bltu_high_chunk_wins", 0);
        send(32'h0000_0005, 32'h0000_0007, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0);
        finish("funct3_010", 0);
        send(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 1'b0, 3'b101, 1'b0, 1'b0);
        finish("bge_stall3", 3);
        // request presented with flush high in IDLE is still accepted
        send(32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0, 3'b100, 1'b0, 1'b1);
        finish("idle_flush_accept", 0);

        // flush during BUSY cycle 2
        send(32'h0000_0000, 32'h0000_0001, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        void'(sb.pop_back());
        tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("flush_valid", bus.o_valid, 0);
        check("flush_ready", bus.o_ready, 1);
        check("flush_less_hold", bus.o_br_less, last_less);
        check("flush_equal_hold", bus.o_br_equal, last_equal);
        check("flush_taken_hold", bus.o_taken, last_taken);
        for (int i = 0; i < NCHUNK + 1; i++) tick();
        check("flush_no_stale", bus.o_valid, 0);
        send(32'hABCD_0000, 32'hABCD_0000, 32'h0, 1'b0, 3'b101, 1'b0, 1'b0);
        finish("after_flush", 0);

        // flush in DONE drops the result without a handshake
        send(32'h0000_0010, 32'h0000_0020, 32'h0, 1'b0, 3'b110, 1'b0, 1'b0);
        for (int i = 0; i < NCHUNK; i++) tick();
        check("done_before_flush", bus.o_valid, 1);
        void'(sb.pop_back());
        bus.i_flush = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        check("done_flush_valid", bus.o_valid, 0);
        check("done_flush_ready", bus.o_ready, 1);
        check("done_flush_less_hold", bus.o_br_less, 1);

        // make outputs non-zero, then reset during BUSY cycle 2
        send(32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        finish("before_rst", 0);
        send(32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        void'(sb.pop_back());
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_ready", bus.o_ready, 1);
        check("midrst_less", bus.o_br_less, 0);
        check("midrst_equal", bus.o_br_equal, 0);
        check("midrst_taken", bus.o_taken, 0);
        for (int i = 0; i < NCHUNK + 1; i++) tick();
        check("midrst_no_stale", bus.o_valid, 0);
        send(32'h8000_0001, 32'h0000_0001, 32'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        finish("after_rst", 0);

        // randomised operands that often share chunks
        for (int k = 0; k < 24; k++) begin
            ra   = $urandom;
            mask = 32'hFF << (8 * $urandom_range(3));
            rb   = ($urandom_range(3) == 0) ? ra : (ra ^ (mask & $urandom));
            rf   = 3'($urandom_range(7));
            send(ra, rb, ~rb, 1'b0, rf, 1'($urandom_range(1)), 1'b0);
            finish("random", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/brc_seq.md
# brc_seq

Parametrised, multi-cycle branch comparator: the successor to the single-cycle combinational branch compare unit. It compares two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, and returns less/equal flags plus a resolved branch-taken bit for the RISC-V branch funct3 encodings. Valid/ready handshakes sit on both sides, so it can be placed in the execute stage of a multi-cycle core or on a narrow-datapath variant where a full-width compare breaks timing.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle. WIDTH % CHUNK != 0 is an elaboration error. NCHUNK = WIDTH/CHUNK.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  request valid.
- o_ready  output  1  request accepted when i_valid && o_ready.
- i_rs1_data  input  WIDTH  operand A.
- i_rs2_data  input  WIDTH  operand B when i_slti_sel = 0.
- i_imm_ext  input  WIDTH  operand B when i_slti_sel = 1.
- i_slti_sel  input  1  select immediate as operand B.
- i_funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- i_br_un  input  1  unsigned compare for o_br_less; ignored when funct3[2:1] = 11, which forces unsigned.
- i_flush  input  1  abandon in-flight compare.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result when o_valid && i_ready.
- o_br_less  output  1  A < B under the selected signedness.
- o_br_equal  output  1  A == B.
- o_taken  output  1  branch condition true for the latched funct3.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - o_ready = 1.
  - On accept, latch A, the selected B, funct3 and unsigned flag (i_br_un | (funct3[2:1] == 11)).
  - Clear chunk counter to 0, set eq_acc = 1 and lt_acc = 0, go to BUSY.
- BUSY, each edge processes chunk cnt (bits [cnt*CHUNK +: CHUNK]):
  - chunks differ: lt_acc <= (a_chunk < b_chunk unsigned), eq_acc <= 0.
  - chunks equal: lt_acc and eq_acc hold.
  - Top chunk in signed mode: invert the MSB of both chunks before the compare (signed-as-offset-unsigned).
  - On cnt == NCHUNK-1, register the results into o_br_less/o_br_equal/o_taken and go to DONE. Otherwise cnt increments.
- o_taken:
  - BEQ: eq.
  - BNE: !eq.
  - BLT/BLTU: lt.
  - BGE/BGEU: !lt.
  - 010 and 011: 0, with less/equal still valid.
- DONE:
  - o_valid = 1. Result outputs stay stable until the handshake.
  - On i_ready, go to IDLE. No new request is accepted in the same cycle.
- i_flush:
  - In BUSY or DONE, go to IDLE next edge with o_valid = 0. Result outputs hold their last value.
  - Flush has priority over i_ready and over completion.
  - Flush in IDLE has no effect. A request presented with i_flush high is still accepted.
- Inputs are sampled only at accept. Changes during BUSY are ignored.

## Timing
- Reset values: state IDLE, o_ready = 1, o_valid = 0, o_br_less = 0, o_br_equal = 0, o_taken = 0, cnt = 0.
- Reset mid-operation: in-flight request dropped, reset values on the next edge.
- Latency: accept at edge E gives o_valid = 1 after edge E+NCHUNK. Example: 4 cycles for 32/8.
- CHUNK = WIDTH gives 1-cycle latency.
- Throughput: one result per NCHUNK+2 cycles with i_ready held high (accept, NCHUNK BUSY edges, DONE handshake edge).
- o_ready and o_valid are pure functions of state. No combinational path from any input to any output.

## Configuration
- BRC_SEQ_EQ_FASTPATH_EN:
  - Defined: BEQ/BNE requests compute equality with a full-width XOR reduction at accept and go straight to DONE. o_valid follows one edge after accept, and o_br_less = 0 for these ops.
  - Undefined: every funct3 takes the NCHUNK-cycle serial path, and o_br_less is always the true compare.

## Test plan
- WIDTH=32, CHUNK=8, BLT, A=0xFFFFFFFF, B=0x00000001 -> o_valid after 4 cycles, o_br_less=1, o_taken=1, o_br_equal=0.
- Same operands, BLTU -> o_br_less=0, o_taken=0. BGEU -> o_taken=1.
- BGE, i_slti_sel=1, A=0x80000000, i_imm_ext=0x80000000, i_rs2_data=0 -> o_br_equal=1, o_br_less=0, o_taken=1.
- BEQ, A=B=0x12345678 -> taken=1. Result is valid 1 cycle after accept with BRC_SEQ_EQ_FASTPATH_EN defined, 4 cycles without.
- Result with i_ready low for 3 cycles -> o_valid and result held stable, o_ready=0. i_ready high -> o_ready=1 the next cycle.
- i_rst or i_flush asserted at BUSY cycle 2:
  - Next edge: o_valid=0, o_ready=1, no stale result.
  - i_rst also clears the outputs to 0.
  - A following request completes correctly.
